memory_reader_ctrl: RTL and testbench

Sequencing controller for the memory reader datapath: drives its address-select, offset-select, buffer write-enables and the three load counters. On a start command it copies the four 16-byte filters, then one image of `IMG_WORDS` 32-bit words, from input memory into the datapath's filter and image buffers. It signals completion to the convolution top-level controller. One memory word is transferred per clock; memory read is combinational and buffers write on `clk`.

---
 rtl/memory_reader_ctrl_pkg.sv | 23 ++
 rtl/memory_reader_ctrl_wrap_counter.sv | 22 ++
 rtl/memory_reader_ctrl.sv | 117 +++++++++++
 tb/tb_memory_reader_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_reader_ctrl_pkg.sv
// Shared types and encodings for the memory reader sequencing controller.
package mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_FILT = 2'd1,
    LD_IMG  = 2'd2,
    DONE    = 2'd3
  } mr_state_t;

  localparam logic ADR_SEL_FILTER = 1'b0;
  localparam logic ADR_SEL_IMG    = 1'b1;

  localparam logic [1:0] OFFSET_Y = 2'd0;
  localparam logic [1:0] OFFSET_X = 2'd1;
  localparam logic [1:0] OFFSET_Z = 2'd2;

  // Terminal count for a counter spanning n values.
  function automatic logic [7:0] last_idx(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/memory_reader_ctrl_wrap_counter.sv
// 8-bit wrapping counter: clear has priority, wraps to 0 after TERMINAL.
module wrap_counter #(
  parameter logic [7:0] TERMINAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count,
  output logic       tc
);

  assign tc = (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= 8'd0;
    else if (en)
      count <= tc ? 8'd0 : count + 8'd1;
  end

endmodule

// File: rtl/memory_reader_ctrl.sv
// Sequences filter and image loads from input memory into the reader datapath,
// one word per clock, and pulses done back to the convolution controller.
module memory_reader_ctrl
  import mem_reader_pkg::*;
#(
  parameter int IMG_WORDS    = 64,
  parameter int FILTER_WORDS = 4,
  parameter int NUM_FILTERS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_filters,
  input  logic       img_src,
  output logic       adr_sel,
  output logic [1:0] mem_offset_sel,
  output logic       filter_wr_en,
  output logic       img_wr_en,
  output logic [7:0] countr_filters,
  output logic [7:0] countr4_filter,
  output logic [7:0] countr_img,
  output logic       busy,
  output logic       done,
  output logic       filters_valid
);

  mr_state_t state;
  logic      img_src_q;
  logic      tc_word, tc_filt, tc_img;
  logic      filt_last, img_last;

  assign filt_last = filter_wr_en && tc_word && tc_filt;
  assign img_last  = img_wr_en && tc_img;

  wrap_counter #(.TERMINAL(last_idx(FILTER_WORDS))) u_cnt_word (
    .clk(clk), .rst(rst), .clr(filt_last), .en(filter_wr_en),
    .count(countr4_filter), .tc(tc_word)
  );

  wrap_counter #(.TERMINAL(last_idx(NUM_FILTERS))) u_cnt_filt (
    .clk(clk), .rst(rst), .clr(filt_last), .en(filter_wr_en && tc_word),
    .count(countr_filters), .tc(tc_filt)
  );

  wrap_counter #(.TERMINAL(last_idx(IMG_WORDS))) u_cnt_img (
    .clk(clk), .rst(rst), .clr(img_last), .en(img_wr_en),
    .count(countr_img), .tc(tc_img)
  );

  // Outputs are assigned alongside the state so they are clean registered decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      img_src_q      <= 1'b0;
      adr_sel        <= ADR_SEL_FILTER;
      mem_offset_sel <= OFFSET_Y;
      filter_wr_en   <= 1'b0;
      img_wr_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      filters_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_src_q <= img_src;
            busy      <= 1'b1;
            if (load_filters || !filters_valid) begin
              state          <= LD_FILT;
              adr_sel        <= ADR_SEL_FILTER;
              mem_offset_sel <= OFFSET_Z;
              filter_wr_en   <= 1'b1;
            end else begin
              state          <= LD_IMG;
              adr_sel        <= ADR_SEL_IMG;
              mem_offset_sel <= {1'b0, img_src};
              img_wr_en      <= 1'b1;
            end
          end
        end
        LD_FILT: begin
          if (filt_last) begin
            state          <= LD_IMG;
            filters_valid  <= 1'b1;
            filter_wr_en   <= 1'b0;
            img_wr_en      <= 1'b1;
            adr_sel        <= ADR_SEL_IMG;
            mem_offset_sel <= {1'b0, img_src_q};
          end
        end
        LD_IMG: begin
          if (img_last) begin
            state          <= DONE;
            img_wr_en      <= 1'b0;
            adr_sel        <= ADR_SEL_FILTER;
            mem_offset_sel <= OFFSET_Y;
            done           <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          adr_sel        <= ADR_SEL_FILTER;
          mem_offset_sel <= OFFSET_Y;
          filter_wr_en   <= 1'b0;
          img_wr_en      <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_reader_ctrl.sv
// Scoreboard bench: a cycle-indexed reference model queues expected outputs,
// a negedge monitor compares every cycle.
module tb_memory_reader_ctrl;

  localparam int IW  = 64;
  localparam int FW  = 4;
  localparam int NF  = 4;
  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, load_filters = 1'b0, img_src = 1'b0;
  logic       adr_sel, filter_wr_en, img_wr_en, busy, done, filters_valid;
  logic [1:0] mem_offset_sel;
  logic [7:0] countr_filters, countr4_filter, countr_img;

  memory_reader_ctrl #(.IMG_WORDS(IW), .FILTER_WORDS(FW), .NUM_FILTERS(NF)) dut (
    .clk(clk), .rst(rst), .start(start), .load_filters(load_filters), .img_src(img_src),
    .adr_sel(adr_sel), .mem_offset_sel(mem_offset_sel), .filter_wr_en(filter_wr_en),
    .img_wr_en(img_wr_en), .countr_filters(countr_filters), .countr4_filter(countr4_filter),
    .countr_img(countr_img), .busy(busy), .done(done), .filters_valid(filters_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fw, iw, dn, adr;
    logic [1:0] off;
    logic [7:0] f, w, im;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int idle_from = 0, fv_from = BIG, busy_lo = 1, busy_hi = 0;
  int checks = 0, failures = 0;

  task automatic check(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void push(input int c, input obs_t o);
    item_t it;
    it.cyc = c;
    it.o   = o;
    q.push_back(it);
  endfunction

  // Reference model: on an accepted start, lay out the whole load cycle by cycle.
  function automatic void accept(input int c, input bit lf, input bit src);
    int   t;
    obs_t o;
    t = c + 1;
    busy_lo = t;
    if (lf || c < fv_from) begin
      for (int i = 0; i < NF * FW; i++) begin
        o = '0;
        o.fw = 1'b1; o.off = 2'd2; o.adr = 1'b0;
        o.f = 8'(i / FW); o.w = 8'(i % FW);
        push(t + i, o);
      end
      t = t + NF * FW;
      if (fv_from > t) fv_from = t;
    end
    for (int j = 0; j < IW; j++) begin
      o = '0;
      o.iw = 1'b1; o.adr = 1'b1; o.off = {1'b0, src}; o.im = 8'(j);
      push(t + j, o);
    end
    t = t + IW;
    o = '0;
    o.dn = 1'b1;
    push(t, o);
    busy_hi   = t;
    idle_from = t + 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        fv_from   = BIG;
        idle_from = cyc + 1;
        busy_lo   = 1;
        busy_hi   = 0;
      end else if (start && cyc >= idle_from) begin
        accept(cyc, load_filters, img_src);
      end
      cyc++;
    end
  end

  initial begin
    obs_t exp_o, act_o;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        exp_o = '0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
          check(1'b0, "stale_expect", 0, longint'(q[0].cyc));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) exp_o = q.pop_front().o;
        act_o = {filter_wr_en, img_wr_en, done, adr_sel, mem_offset_sel,
                 countr_filters, countr4_filter, countr_img};
        check(act_o === exp_o, "outputs", longint'(act_o), longint'(exp_o));
        check(!(filter_wr_en && img_wr_en), "wr_exclusive",
              longint'({filter_wr_en, img_wr_en}), 0);
        check(busy === (cyc >= busy_lo && cyc <= busy_hi), "busy",
              longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
        check(filters_valid === (cyc >= fv_from), "filters_valid",
              longint'(filters_valid), longint'(cyc >= fv_from));
      end
    end
  end

  task automatic do_start(input bit lf, input bit src, output int c);
    start = 1'b1; load_filters = lf; img_src = src;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < idle_from && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check(1'b0, "idle_timeout", longint'(cyc), longint'(idle_from));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check({adr_sel, mem_offset_sel, filter_wr_en, img_wr_en, busy, done, filters_valid} === 8'h00,
          "reset_ctrl", longint'({adr_sel, mem_offset_sel, filter_wr_en, img_wr_en,
          busy, done, filters_valid}), 0);
    check({countr_filters, countr4_filter, countr_img} === 24'h0, "reset_counters",
          longint'({countr_filters, countr4_filter, countr_img}), 0);
  endtask

  initial begin
    int c, d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    do_start(1'b1, 1'b0, c);
    wait_idle();
    check(filters_valid === 1'b1, "fv_after_full", longint'(filters_valid), 1);
    do_start(1'b0, 1'b1, c);
    wait_idle();

    // Reset clears filters_valid, so an image-only request still loads filters.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check_reset_vals();
    do_start(1'b0, 1'b0, c);
    wait_idle();

    // Start pulse in the middle of a load is dropped.
    do_start(1'b1, 1'b0, c);
    wait_until(c + 30);
    do_start(1'b0, 1'b1, d);
    wait_idle();

    // Reset in cycle 20 of a load, then a clean full load.
    do_start(1'b1, 1'b0, c);
    wait_until(c + 20);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check_reset_vals();
    do_start(1'b1, 1'b1, c);
    wait_idle();

    for (int it = 0; it < 30; it++) begin
      int r;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_start(1'($urandom), 1'($urandom), c);
      r = $urandom_range(0, 9);
      if (r < 3) begin
        wait_until(c + $urandom_range(1, 85));
        do_start(1'($urandom), 1'($urandom), d);
      end else if (r == 3) begin
        wait_until(c + $urandom_range(1, 80));
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check(q.size() == 0, "queue_drained", longint'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
